fp_unit_arbiter: RTL

Round-robin scheduler that shares one fully pipelined, fixed-latency floating-point core (fpExp, fpLog, fpMult, etc.) among several effect-stage requesters. It issues at most one operation per cycle into the core and tracks the owner of each in-flight operation in a tag pipeline matched to the core latency. It steers each result back to the requester that issued it as a one-cycle pulse. The block sits between the effect datapaths and a single core instance, so each effect no longer needs its own core plus a `done` counter.

---
 rtl/fp_arb_pkg.sv | 18 +
 rtl/fp_unit_arbiter_rr_arbiter.sv | 31 +++
 rtl/fp_unit_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/fp_arb_pkg.sv
// Shared constants and types for the floating-point unit arbiter.
// Tag entries track ownership of operations in flight through the core.
package fp_arb_pkg;

    localparam int FP_DATA_W = 32;

    // Core latencies in clock edges from operand sample to valid result.
    localparam int FP_EXP_LATENCY = 17;

    // Requester id width sized for the largest supported requester count (8).
    localparam int FP_ARB_ID_W = 3;

    typedef struct packed {
        logic                   valid;
        logic [FP_ARB_ID_W-1:0] id;
    } fp_tag_t;

endpackage

// File: rtl/fp_unit_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
// The search for a set request starts at rr_ptr and wraps around.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_id,
    output logic          any_grant
);

    // First set request at or after rr_ptr, modulo N, wins.
    always_comb begin
        int idx;
        grant     = '0;
        grant_id  = '0;
        any_grant = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(rr_ptr) + k) % N;
            if (!any_grant && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IW'(idx);
                any_grant  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_unit_arbiter.sv
// Shares one fixed-latency pipelined FP core among N_REQ requesters.
// A tag pipeline matched to the core latency steers results to owners.
module fp_unit_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int LATENCY = FP_EXP_LATENCY,
    parameter int DATA_W  = FP_DATA_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        grant,
    output logic                    core_clk_en,
    output logic [DATA_W-1:0]       core_data,
    input  logic [DATA_W-1:0]       core_result,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    busy
);

    localparam int IW = $clog2(N_REQ);

    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant_id;
    logic          any_grant;
    fp_tag_t       tags [LATENCY];

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IW)
    ) u_rr (
        .req       (req),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_id  (grant_id),
        .any_grant (any_grant)
    );

    // Operand mux: granted requester's slice, zero when nobody is granted.
    always_comb begin
        core_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                core_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Any live tag means the core holds an operation in flight.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k < LATENCY; k++) begin
            busy = busy | tags[k].valid;
        end
    end

    // Freeze the core only when idle, so live data never stalls inside it.
    assign core_clk_en = (|req) | busy;

    // Pointer moves past the winner after each transfer, else holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
        end
    end

    // Tag pipeline advances in lockstep with the core's clock enable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < LATENCY; k++) begin
                tags[k] <= '{valid: 1'b0, id: '0};
            end
        end else if (core_clk_en) begin
            tags[0] <= '{valid: any_grant, id: FP_ARB_ID_W'(grant_id)};
            for (int k = 1; k < LATENCY; k++) begin
                tags[k] <= tags[k-1];
            end
        end
    end

    // Route the core output to the owner of the retiring tag as a pulse.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (tags[LATENCY-1].valid &&
                tags[LATENCY-1].id == FP_ARB_ID_W'(i)) begin
                rsp_valid[i] = 1'b1;
                rsp_data     = core_result;
            end
        end
    end

endmodule
